// File: rtl/mpu_mem_port.sv
`timescale 1ns/1ps
// mpu_mem_port: memory-side responder of the MPU. Streams matrices from memory into
// the matrix register file (load) and from the register file out to memory (store).
module mpu_mem_port #(
  parameter int M               = 6,
  parameter int N               = 6,
  parameter int MBITS           = $clog2(M),
  parameter int NBITS           = $clog2(N),
  parameter int MATRIX_REG_BITS = 3,
  parameter int FW              = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_req,
  input  logic [MBITS:0]             mem_m_load_size,
  input  logic [NBITS:0]             mem_n_load_size,
  input  logic [MATRIX_REG_BITS:0]   mem_load_addr,
  input  logic [FW-1:0]              mem_load_element,
  output logic                       mem_load_ack,
  output logic                       mem_load_error,
  output logic                       load_ready,
  input  logic                       store_req,
  input  logic [MATRIX_REG_BITS:0]   mem_store_addr,
  output logic                       mem_store_en,
  output logic [FW-1:0]              mem_store_element,
  output logic [MBITS:0]             mem_m_store_size,
  output logic [NBITS:0]             mem_n_store_size,
  output logic                       store_ready,
  output logic                       reg_load_req,
  output logic [MATRIX_REG_BITS:0]   reg_load_addr,
  output logic [FW-1:0]              reg_load_element,
  output logic [MBITS:0]             reg_i_load_loc,
  output logic [NBITS:0]             reg_j_load_loc,
  output logic [MBITS:0]             reg_m_load_size,
  output logic [NBITS:0]             reg_n_load_size,
  output logic                       reg_store_req,
  output logic [MATRIX_REG_BITS:0]   reg_store_addr,
  output logic [MBITS:0]             reg_i_store_loc,
  output logic [NBITS:0]             reg_j_store_loc,
  input  logic [FW-1:0]              reg_store_element,
  input  logic [MBITS:0]             reg_m_store_size,
  input  logic [NBITS:0]             reg_n_store_size
);

  localparam int CW = $clog2(M*N+1);
  localparam int TW = MBITS + NBITS + 2;

  localparam logic [MBITS:0] M_LIM = M[MBITS:0];
  localparam logic [NBITS:0] N_LIM = N[NBITS:0];
  localparam logic [MBITS:0] M_ONE = (MBITS+1)'(1);
  localparam logic [NBITS:0] N_ONE = (NBITS+1)'(1);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_LOAD        = 3'd1;
  localparam logic [2:0] S_LOAD_WAIT   = 3'd2;
  localparam logic [2:0] S_ERR_WAIT    = 3'd3;
  localparam logic [2:0] S_STORE_PRIME = 3'd4;
  localparam logic [2:0] S_STORE       = 3'd5;
  localparam logic [2:0] S_STORE_WAIT  = 3'd6;

  logic [2:0]               state_q, state_d;

  // load side
  logic [MBITS:0]           ld_m_q, ld_m_d;
  logic [NBITS:0]           ld_n_q, ld_n_d;
  logic [MATRIX_REG_BITS:0] ld_addr_q, ld_addr_d;
  logic [MBITS:0]           ld_i_q, ld_i_d;
  logic [NBITS:0]           ld_j_q, ld_j_d;
  logic [CW-1:0]            ld_cnt_q, ld_cnt_d;
  logic                     ack_q, ack_d;
  logic                     err_q, err_d;
  logic                     wr_req_q, wr_req_d;
  logic [FW-1:0]            wr_elem_q, wr_elem_d;
  logic [MBITS:0]           wr_i_q, wr_i_d;
  logic [NBITS:0]           wr_j_q, wr_j_d;

  // store side
  logic [MATRIX_REG_BITS:0] st_addr_q, st_addr_d;
  logic [MBITS:0]           st_m_q, st_m_d;
  logic [NBITS:0]           st_n_q, st_n_d;
  logic                     first_q, first_d;
  logic [MBITS:0]           rd_i_q, rd_i_d;
  logic [NBITS:0]           rd_j_q, rd_j_d;
  logic [CW-1:0]            rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]            ret_cnt_q, ret_cnt_d;
  logic                     rd_pend_q, rd_pend_d;
  logic                     en_q, en_d;
  logic [FW-1:0]            st_elem_q, st_elem_d;

  logic [TW-1:0]            ld_total, st_total;
  logic [MBITS:0]           sz_m, nxt_i;
  logic [NBITS:0]           sz_n, nxt_j;
  logic                     rd_issue, ld_bad;

  assign ld_total = TW'(ld_m_q) * TW'(ld_n_q);
  assign ld_bad   = (mem_m_load_size == '0) || (mem_n_load_size == '0) ||
                    (mem_m_load_size > M_LIM) || (mem_n_load_size > N_LIM);

  // Read data and sizes arrive one cycle after the priming read, so the first
  // STORE cycle works from the live register-file sizes, later ones from the latch.
  assign sz_m     = first_q ? reg_m_store_size : st_m_q;
  assign sz_n     = first_q ? reg_n_store_size : st_n_q;
  assign st_total = TW'(sz_m) * TW'(sz_n);

  always_comb begin
    nxt_i = '0;
    nxt_j = '0;
    if (state_q == S_STORE) begin
      if (rd_j_q == sz_n - N_ONE) begin
        nxt_i = rd_i_q + M_ONE;
      end else begin
        nxt_i = rd_i_q;
        nxt_j = rd_j_q + N_ONE;
      end
    end
  end

  assign rd_issue = (state_q == S_STORE_PRIME) ||
                    ((state_q == S_STORE) && (TW'(rd_cnt_q) < st_total));

  // NOTE: every _d starts from its _q (or from 0 for one-cycle strobes) so that no
  // path through the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    ld_m_d    = ld_m_q;
    ld_n_d    = ld_n_q;
    ld_addr_d = ld_addr_q;
    ld_i_d    = ld_i_q;
    ld_j_d    = ld_j_q;
    ld_cnt_d  = ld_cnt_q;
    ack_d     = ack_q;
    err_d     = 1'b0;
    wr_req_d  = 1'b0;
    wr_elem_d = wr_elem_q;
    wr_i_d    = wr_i_q;
    wr_j_d    = wr_j_q;
    st_addr_d = st_addr_q;
    st_m_d    = st_m_q;
    st_n_d    = st_n_q;
    first_d   = first_q;
    rd_i_d    = rd_i_q;
    rd_j_d    = rd_j_q;
    rd_cnt_d  = rd_cnt_q;
    ret_cnt_d = ret_cnt_q;
    rd_pend_d = 1'b0;
    en_d      = 1'b0;
    st_elem_d = st_elem_q;

    case (state_q)
      S_IDLE: begin
        if (load_req) begin
          ld_m_d    = mem_m_load_size;
          ld_n_d    = mem_n_load_size;
          ld_addr_d = mem_load_addr;
          ld_i_d    = '0;
          ld_j_d    = '0;
          ld_cnt_d  = '0;
          if (ld_bad) begin
            err_d   = 1'b1;
            state_d = S_ERR_WAIT;
          end else begin
            ack_d   = 1'b1;
            state_d = S_LOAD;
          end
        end else if (store_req) begin
          st_addr_d = mem_store_addr;
          state_d   = S_STORE_PRIME;
        end
      end

      S_LOAD: begin
        wr_req_d  = 1'b1;
        wr_elem_d = mem_load_element;
        wr_i_d    = ld_i_q;
        wr_j_d    = ld_j_q;
        ld_cnt_d  = ld_cnt_q + CW'(1);
        if (ld_j_q == ld_n_q - N_ONE) begin
          ld_j_d = '0;
          ld_i_d = ld_i_q + M_ONE;
        end else begin
          ld_j_d = ld_j_q + N_ONE;
        end
        if (TW'(ld_cnt_q) + TW'(1) == ld_total) begin
          ack_d   = 1'b0;
          state_d = S_LOAD_WAIT;
        end
      end

      S_LOAD_WAIT, S_ERR_WAIT: begin
        if (!load_req) state_d = S_IDLE;
      end

      S_STORE_PRIME: begin
        rd_i_d    = '0;
        rd_j_d    = '0;
        rd_cnt_d  = CW'(1);
        ret_cnt_d = '0;
        rd_pend_d = 1'b1;
        first_d   = 1'b1;
        state_d   = S_STORE;
      end

      S_STORE: begin
        first_d = 1'b0;
        if (first_q) begin
          st_m_d = reg_m_store_size;
          st_n_d = reg_n_store_size;
        end
        if (rd_issue) begin
          rd_i_d   = nxt_i;
          rd_j_d   = nxt_j;
          rd_cnt_d = rd_cnt_q + CW'(1);
        end
        rd_pend_d = rd_issue;
        if (st_total == '0) begin
          rd_pend_d = 1'b0;
          state_d   = S_STORE_WAIT;
        end else if (rd_pend_q) begin
          en_d      = 1'b1;
          st_elem_d = reg_store_element;
          ret_cnt_d = ret_cnt_q + CW'(1);
          if (TW'(ret_cnt_q) + TW'(1) == st_total) state_d = S_STORE_WAIT;
        end
      end

      S_STORE_WAIT: begin
        if (!store_req) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ld_m_q    <= '0;
      ld_n_q    <= '0;
      ld_addr_q <= '0;
      ld_i_q    <= '0;
      ld_j_q    <= '0;
      ld_cnt_q  <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      wr_req_q  <= 1'b0;
      wr_elem_q <= '0;
      wr_i_q    <= '0;
      wr_j_q    <= '0;
      st_addr_q <= '0;
      st_m_q    <= '0;
      st_n_q    <= '0;
      first_q   <= 1'b0;
      rd_i_q    <= '0;
      rd_j_q    <= '0;
      rd_cnt_q  <= '0;
      ret_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      en_q      <= 1'b0;
      st_elem_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_m_q    <= ld_m_d;
      ld_n_q    <= ld_n_d;
      ld_addr_q <= ld_addr_d;
      ld_i_q    <= ld_i_d;
      ld_j_q    <= ld_j_d;
      ld_cnt_q  <= ld_cnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      wr_req_q  <= wr_req_d;
      wr_elem_q <= wr_elem_d;
      wr_i_q    <= wr_i_d;
      wr_j_q    <= wr_j_d;
      st_addr_q <= st_addr_d;
      st_m_q    <= st_m_d;
      st_n_q    <= st_n_d;
      first_q   <= first_d;
      rd_i_q    <= rd_i_d;
      rd_j_q    <= rd_j_d;
      rd_cnt_q  <= rd_cnt_d;
      ret_cnt_q <= ret_cnt_d;
      rd_pend_q <= rd_pend_d;
      en_q      <= en_d;
      st_elem_q <= st_elem_d;
    end
  end

  assign load_ready        = (state_q == S_IDLE);
  assign store_ready       = (state_q == S_IDLE);
  assign mem_load_ack      = ack_q;
  assign mem_load_error    = err_q;
  assign reg_load_req      = wr_req_q;
  assign reg_load_addr     = ld_addr_q;
  assign reg_load_element  = wr_elem_q;
  assign reg_i_load_loc    = wr_i_q;
  assign reg_j_load_loc    = wr_j_q;
  assign reg_m_load_size   = ld_m_q;
  assign reg_n_load_size   = ld_n_q;
  assign reg_store_req     = rd_issue;
  assign reg_store_addr    = st_addr_q;
  assign reg_i_store_loc   = rd_issue ? nxt_i : '0;
  assign reg_j_store_loc   = rd_issue ? nxt_j : '0;
  assign mem_store_en      = en_q;
  assign mem_store_element = st_elem_q;
  assign mem_m_store_size  = st_m_q;
  assign mem_n_store_size  = st_n_q;

endmodule

// File: tb/tb_mpu_mem_port.sv
`timescale 1ns/1ps
// Randomised bench for mpu_mem_port: a matrix-level reference model feeds expectation
// queues; a monitor on the falling edge pops and compares whatever the DUT presents.
module tb_mpu_mem_port;

  localparam int FW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_req = 1'b0, store_req = 1'b0;
  logic [3:0]    mem_m_load_size = '0, mem_n_load_size = '0;
  logic [3:0]    mem_load_addr = '0, mem_store_addr = '0;
  logic [FW-1:0] mem_load_element = '0;
  logic [FW-1:0] reg_store_element = '0;
  logic [3:0]    reg_m_store_size = '0, reg_n_store_size = '0;

  logic          mem_load_ack, mem_load_error, load_ready;
  logic          mem_store_en, store_ready;
  logic [FW-1:0] mem_store_element;
  logic [3:0]    mem_m_store_size, mem_n_store_size;
  logic          reg_load_req, reg_store_req;
  logic [3:0]    reg_load_addr, reg_i_load_loc, reg_j_load_loc;
  logic [3:0]    reg_m_load_size, reg_n_load_size;
  logic [FW-1:0] reg_load_element;
  logic [3:0]    reg_store_addr, reg_i_store_loc, reg_j_store_loc;

  always #5 clk = ~clk;

  mpu_mem_port dut (
    .clk(clk), .rst(rst),
    .load_req(load_req), .mem_m_load_size(mem_m_load_size), .mem_n_load_size(mem_n_load_size),
    .mem_load_addr(mem_load_addr), .mem_load_element(mem_load_element),
    .mem_load_ack(mem_load_ack), .mem_load_error(mem_load_error), .load_ready(load_ready),
    .store_req(store_req), .mem_store_addr(mem_store_addr), .mem_store_en(mem_store_en),
    .mem_store_element(mem_store_element), .mem_m_store_size(mem_m_store_size),
    .mem_n_store_size(mem_n_store_size), .store_ready(store_ready),
    .reg_load_req(reg_load_req), .reg_load_addr(reg_load_addr),
    .reg_load_element(reg_load_element), .reg_i_load_loc(reg_i_load_loc),
    .reg_j_load_loc(reg_j_load_loc), .reg_m_load_size(reg_m_load_size),
    .reg_n_load_size(reg_n_load_size), .reg_store_req(reg_store_req),
    .reg_store_addr(reg_store_addr), .reg_i_store_loc(reg_i_store_loc),
    .reg_j_store_loc(reg_j_store_loc), .reg_store_element(reg_store_element),
    .reg_m_store_size(reg_m_store_size), .reg_n_store_size(reg_n_store_size)
  );

  typedef struct packed {
    logic [3:0]  addr;
    logic [3:0]  i;
    logic [3:0]  j;
    logic [31:0] elem;
    logic [3:0]  m;
    logic [3:0]  n;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  int          exp_first_en[$];
  bit          exp_err[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // reference model: matrix contents and sizes per register
  logic [31:0] mdl [16][6][6];
  int          mdl_m [16];
  int          mdl_n [16];

  // register-file responder state
  logic [31:0] rf [16][6][6];
  logic [3:0]  rf_m [16];
  logic [3:0]  rf_n [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] f32(input int k);
    int e;
    logic [31:0] mant;
    e = 0;
    while ((k >> (e + 1)) != 0) e++;
    mant = (32'(k) << (23 - e)) & 32'h007F_FFFF;
    return {1'b0, 8'(127 + e), mant[22:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read register file: read data and sizes appear just after the edge
  // that follows the read request, and hold for one full cycle.
  logic       rd_pend = 1'b0;
  logic [3:0] rd_a = '0, rd_i = '0, rd_j = '0;
  always @(negedge clk) begin
    rd_pend = reg_store_req;
    rd_a    = reg_store_addr;
    rd_i    = reg_i_store_loc;
    rd_j    = reg_j_store_loc;
    if (reg_load_req && reg_i_load_loc < 6 && reg_j_load_loc < 6) begin
      rf[reg_load_addr][reg_i_load_loc][reg_j_load_loc] = reg_load_element;
      rf_m[reg_load_addr] = reg_m_load_size;
      rf_n[reg_load_addr] = reg_n_load_size;
    end
  end
  always @(posedge clk) begin
    #1;
    if (rd_pend && rd_i < 6 && rd_j < 6) begin
      reg_store_element = rf[rd_a][rd_i][rd_j];
      reg_m_store_size  = rf_m[rd_a];
      reg_n_store_size  = rf_n[rd_a];
    end
  end

  // monitor
  bit  prev_en  = 1'b0;
  bit  prev_err = 1'b0;
  wr_t mon_exp, mon_act;
  int  mon_first;
  always @(negedge clk) begin
    if (!rst) begin
      prev_en  = 1'b0;
      prev_err = 1'b0;
    end else begin
      if (reg_load_req) begin
        check("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0) begin
          mon_exp = exp_wr.pop_front();
          mon_act = '{reg_load_addr, reg_i_load_loc, reg_j_load_loc, reg_load_element,
                      reg_m_load_size, reg_n_load_size};
          check("wr_record", 64'(mon_act), 64'(mon_exp));
        end
      end
      if (mem_store_en) begin
        if (!prev_en && exp_first_en.size() != 0) begin
          mon_first = exp_first_en.pop_front();
          if (mon_first >= 0) check("en_latency", 64'(cyc), 64'(mon_first));
        end
        check("rd_expected", 64'(exp_rd.size() != 0), 64'd1);
        if (exp_rd.size() != 0) check("rd_element", 64'(mem_store_element), 64'(exp_rd.pop_front()));
      end
      if (mem_load_error) begin
        check("err_expected", 64'(exp_err.size() != 0), 64'd1);
        if (exp_err.size() != 0) void'(exp_err.pop_front());
        check("err_one_cycle", 64'(prev_err), 64'd0);
      end
      prev_en  = mem_store_en;
      prev_err = mem_load_error;
    end
  end

  task automatic push_store_exp(input logic [3:0] addr, input int first_cyc);
    for (int r = 0; r < mdl_m[addr]; r++)
      for (int c = 0; c < mdl_n[addr]; c++)
        exp_rd.push_back(mdl[addr][r][c]);
    if (mdl_m[addr] * mdl_n[addr] > 0) exp_first_en.push_back(first_cyc);
  endtask

  task automatic do_load(input logic [3:0] addr, input logic [3:0] m, input logic [3:0] n,
                         input bit seq, input bit with_store);
    logic [31:0] data[$];
    logic [31:0] d;
    int  acks, k, srq;
    bit  legal, seen;
    acks = 0; k = 0; srq = 0; seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (load_ready) break;
      @(negedge clk);
    end
    check("load_ready_wait", 64'(load_ready), 64'd1);
    legal = (m >= 1) && (m <= 6) && (n >= 1) && (n <= 6);
    if (legal) begin
      for (int r = 0; r < int'(m); r++)
        for (int c = 0; c < int'(n); c++) begin
          d = seq ? f32(r * int'(n) + c + 1) : $urandom;
          data.push_back(d);
          exp_wr.push_back('{addr, 4'(r), 4'(c), d, m, n});
          mdl[addr][r][c] = d;
        end
      mdl_m[addr] = int'(m);
      mdl_n[addr] = int'(n);
    end else begin
      exp_err.push_back(1'b1);
    end
    if (with_store) begin
      push_store_exp(addr, -1);
      store_req      = 1'b1;
      mem_store_addr = addr;
    end
    load_req        = 1'b1;
    mem_m_load_size = m;
    mem_n_load_size = n;
    mem_load_addr   = addr;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (reg_store_req) srq++;
      if (mem_load_ack) begin
        acks++;
        seen = 1'b1;
        mem_load_element = (k < data.size()) ? data[k] : $urandom;
        k++;
      end else if (seen || (!legal && c >= 3)) begin
        break;
      end
    end
    check("ack_cycles", 64'(acks), legal ? 64'(int'(m) * int'(n)) : 64'd0);
    if (with_store) check("no_store_during_load", 64'(srq), 64'd0);
    load_req = 1'b0;
    @(negedge clk);
    check("load_ready_after", 64'(load_ready), 64'd1);
  endtask

  task automatic store_start(input logic [3:0] addr);
    for (int c = 0; c < 100; c++) begin
      if (store_ready) break;
      @(negedge clk);
    end
    check("store_ready_wait", 64'(store_ready), 64'd1);
    push_store_exp(addr, cyc + 3);
    store_req      = 1'b1;
    mem_store_addr = addr;
  endtask

  task automatic store_finish(input logic [3:0] addr, input int abort_at);
    int ens;
    bit seen;
    ens = 0; seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (mem_store_en) begin
        ens++;
        seen = 1'b1;
        if (ens == abort_at) begin
          rst = 1'b0;
          #1;
          check("abort_en", 64'(mem_store_en), 64'd0);
          check("abort_store_ready", 64'(store_ready), 64'd1);
          check("abort_load_ready", 64'(load_ready), 64'd1);
          check("abort_rd_req", 64'(reg_store_req), 64'd0);
          exp_rd.delete();
          exp_first_en.delete();
          store_req = 1'b0;
          @(negedge clk);
          check("abort_size_cleared", 64'(mem_m_store_size), 64'd0);
          rst = 1'b1;
          return;
        end
      end else if (seen || c >= 6) begin
        break;
      end
    end
    check("en_cycles", 64'(ens), 64'(mdl_m[addr] * mdl_n[addr]));
    check("store_m_size", 64'(mem_m_store_size), 64'(mdl_m[addr]));
    check("store_n_size", 64'(mem_n_store_size), 64'(mdl_n[addr]));
    store_req = 1'b0;
    @(negedge clk);
    check("store_ready_after", 64'(store_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a, m, n;
    for (int r = 0; r < 16; r++) begin
      mdl_m[r] = 0;
      mdl_n[r] = 0;
      rf_m[r]  = '0;
      rf_n[r]  = '0;
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++) begin
          mdl[r][i][j] = '0;
          rf[r][i][j]  = '0;
        end
    end

    #12;
    check("rst_load_ready", 64'(load_ready), 64'd1);
    check("rst_store_ready", 64'(store_ready), 64'd1);
    check("rst_ack", 64'(mem_load_ack), 64'd0);
    check("rst_err", 64'(mem_load_error), 64'd0);
    check("rst_en", 64'(mem_store_en), 64'd0);
    check("rst_wr_req", 64'(reg_load_req), 64'd0);
    check("rst_rd_req", 64'(reg_store_req), 64'd0);
    check("rst_store_size", 64'({mem_m_store_size, mem_n_store_size}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 2x3 of 1.0..6.0 into register 1, then read it back
    do_load(4'd1, 4'd2, 4'd3, 1'b1, 1'b0);
    store_start(4'd1);
    store_finish(4'd1, 0);

    // illegal sizes
    do_load(4'd3, 4'd0, 4'd3, 1'b0, 1'b0);
    do_load(4'd3, 4'd7, 4'd2, 1'b0, 1'b0);
    do_load(4'd3, 4'd2, 4'd7, 1'b0, 1'b0);

    // never-written register: zero sizes, no data
    store_start(4'd3);
    store_finish(4'd3, 0);

    // simultaneous requests: load first, store after load_req drops
    do_load(4'd4, 4'd3, 4'd2, 1'b0, 1'b1);
    store_finish(4'd4, 0);

    // full 6x6
    do_load(4'd2, 4'd6, 4'd6, 1'b1, 1'b0);
    store_start(4'd2);
    store_finish(4'd2, 0);

    // reset during the third element of a 6x6 store, then a normal store
    store_start(4'd2);
    store_finish(4'd2, 3);
    store_start(4'd1);
    store_finish(4'd1, 0);

    for (int it = 0; it < 25; it++) begin
      a = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 5) == 0) begin
          m = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(7, 15));
          n = 4'($urandom_range(1, 6));
          if ($urandom_range(0, 1) == 0) begin
            n = m;
            m = 4'($urandom_range(1, 6));
          end
        end else begin
          m = 4'($urandom_range(1, 6));
          n = 4'($urandom_range(1, 6));
        end
        do_load(a, m, n, 1'b0, 1'b0);
      end else begin
        store_start(a);
        store_finish(a, 0);
      end
    end

    repeat (4) @(negedge clk);
    check("wr_left", 64'(exp_wr.size()), 64'd0);
    check("rd_left", 64'(exp_rd.size()), 64'd0);
    check("err_left", 64'(exp_err.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
